// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and constants for the imem port arbiter.
// Response-owner encoding plus width/starvation defaults.
package imem_port_arbiter_pkg;

  localparam int DATA_W_C       = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IF    = 2'd1,
    OWN_LS_RD = 2'd2,
    OWN_LS_WR = 2'd3
  } rsp_own_e;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// IF / LS / SRAM signal bundle of the imem port arbiter.
// slave = arbiter side, master = requesters and memory.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              i_if_flush;
  logic              i_if_hold;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;
  logic              o_stall_f;
  logic              i_ls_req;
  logic              i_ls_we;
  logic [3:0]        i_ls_wstrb;
  logic [ADDR_W-1:0] i_ls_addr;
  logic [DATA_W-1:0] i_ls_wdata;
  logic              o_ls_gnt;
  logic              o_ls_rvalid;
  logic [DATA_W-1:0] o_ls_rdata;
  logic              o_mem_en;
  logic [3:0]        o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_if_flush, i_if_hold,
    input  i_ls_req, i_ls_we, i_ls_wstrb, i_ls_addr,
    input  i_ls_wdata, i_mem_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_stall_f,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_if_req, i_if_addr, i_if_flush, i_if_hold,
    output i_ls_req, i_ls_we, i_ls_wstrb, i_ls_addr,
    output i_ls_wdata, i_mem_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_stall_f,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

endinterface

// File: rtl/DFF_RST_EN_CLR.sv
// Register primitive: sync active-low reset, clear, enable.
// clr has priority over en.
module DFF_RST_EN_CLR #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // state update: reset, then clear, then load
  always_ff @(posedge clk) begin
    if (!rst_n)   q <= RST_VAL;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/imem_if_skid.sv
// IF return path: instruction hold register plus a
// 1-entry skid that parks a response arriving under hold.
module imem_if_skid #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              hold,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
);

  logic              full_q;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] data_q;
  logic              present;
  logic              direct;
  logic              stash;
  logic [DATA_W-1:0] load_d;

  assign present = rst_n & full_q & ~hold;
  assign direct  = rsp_valid & ~hold;
  assign stash   = rsp_valid & hold;
  assign rvalid  = present | direct;
  assign load_d  = present ? skid_q : rsp_data;
  assign rdata   = rvalid ? load_d : data_q;
  // a response landing under hold fills the skid next edge
  assign busy    = full_q | stash;

  DFF_RST_EN_CLR #(.W(1)) u_full (
    .clk(clk), .rst_n(rst_n), .en(stash), .clr(present),
    .d(1'b1), .q(full_q)
  );

  DFF_RST_EN_CLR #(.W(DATA_W)) u_skid (
    .clk(clk), .rst_n(rst_n), .en(stash), .clr(1'b0),
    .d(rsp_data), .q(skid_q)
  );

  DFF_RST_EN_CLR #(.W(DATA_W)) u_data (
    .clk(clk), .rst_n(rst_n), .en(rvalid), .clr(1'b0),
    .d(load_d), .q(data_q)
  );

endmodule

// File: rtl/imem_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and
// load/store, with starvation guard and response routing.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = DATA_W_C,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk_sys,
  input  logic                rst_sys,
  imem_port_arbiter_if.slave  bus
);

  rsp_own_e          own_q;
  rsp_own_e          own_d;
  logic [1:0]        own_raw;
  logic [3:0]        starve_q;
  logic              starve_hit;
  logic              if_busy;
  logic              if_ok;
  logic              if_gnt;
  logic              ls_gnt;
  logic              if_rsp;
  logic              ls_rd;
  logic [ADDR_W-1:0] gnt_addr;

  assign starve_hit = starve_q == 4'(STARVE_MAX);
  assign if_ok  = rst_sys & bus.i_if_req & ~if_busy;
  assign if_gnt = if_ok & (~bus.i_ls_req | starve_hit);
  assign ls_gnt = rst_sys & bus.i_ls_req & ~if_gnt;

  assign bus.o_if_gnt  = if_gnt;
  assign bus.o_ls_gnt  = ls_gnt;
  assign bus.o_stall_f = bus.i_if_req & ~if_gnt;

  // memory request is a copy of the winning port
  always_comb begin
    gnt_addr          = '0;
    bus.o_mem_we      = 4'h0;
    bus.o_mem_wdata   = '0;
    if (ls_gnt) begin
      gnt_addr        = bus.i_ls_addr;
      bus.o_mem_wdata = bus.i_ls_wdata;
      if (bus.i_ls_we) bus.o_mem_we = bus.i_ls_wstrb;
    end else if (if_gnt) begin
      gnt_addr        = bus.i_if_addr;
    end
  end

  assign bus.o_mem_en   = if_gnt | ls_gnt;
  assign bus.o_mem_addr = gnt_addr & ~ADDR_W'(3);

  // next response owner from this cycle's grant
  always_comb begin
    own_d = OWN_NONE;
    unique case (1'b1)
      if_gnt:  own_d = bus.i_if_flush ? OWN_NONE : OWN_IF;
      ls_gnt:  own_d = bus.i_ls_we ? OWN_LS_WR : OWN_LS_RD;
      default: own_d = OWN_NONE;
    endcase
  end

  DFF_RST_EN_CLR #(.W(2)) u_own (
    .clk(clk_sys), .rst_n(rst_sys), .en(1'b1), .clr(1'b0),
    .d(own_d), .q(own_raw)
  );

  assign own_q = rsp_own_e'(own_raw);

  DFF_RST_EN_CLR #(.W(4)) u_starve (
    .clk(clk_sys), .rst_n(rst_sys),
    .en(ls_gnt & ~starve_hit),
    .clr(if_gnt | ~bus.i_if_req),
    .d(starve_q + 4'd1), .q(starve_q)
  );

  assign if_rsp = rst_sys & (own_q == OWN_IF) & ~bus.i_if_flush;
  assign ls_rd  = rst_sys & (own_q == OWN_LS_RD);

  assign bus.o_ls_rvalid = ls_rd |
                           (rst_sys & (own_q == OWN_LS_WR));
  assign bus.o_ls_rdata  = ls_rd ? bus.i_mem_rdata : '0;

  imem_if_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk_sys),
    .rst_n     (rst_sys),
    .rsp_valid (if_rsp),
    .rsp_data  (bus.i_mem_rdata),
    .hold      (bus.i_if_hold),
    .rdata     (bus.o_if_rdata),
    .rvalid    (bus.o_if_rvalid),
    .busy      (if_busy)
  );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed vector table
// followed by random traffic against a reference model.
module tb_imem_port_arbiter;

  localparam int STARVE = 4;

  typedef struct {
    bit          rst;
    bit          ir;
    logic [31:0] ia;
    bit          fl;
    bit          hd;
    bit          lr;
    bit          lw;
    logic [31:0] la;
    bit          gi;
    bit          gl;
    bit          rvi;
    logic [31:0] rdi;
    bit          rvl;
    logic [31:0] rdl;
    bit          st;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  logic [31:0] sram [256];
  logic [31:0] mdl_mem [256];
  logic [31:0] mem_q;

  int          mdl_starve;
  int          mdl_pend;
  logic [31:0] mdl_pdata;
  logic [31:0] mdl_held;
  logic [31:0] mdl_skd;
  bit          mdl_full;

  vec_t tbl [26];

  imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE)
  ) dut (
    .clk_sys (clk),
    .rst_sys (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(int i);
    logic [7:0] b;
    b = 8'(i);
    case (i)
      0:       return 32'h0000_0013;
      1:       return 32'h0000_0093;
      2:       return 32'h0000_0113;
      4:       return 32'h0040_0093;
      8:       return 32'h1111_1111;
      12:      return 32'hDEAD_BEEF;
      13:      return 32'h2222_2222;
      64:      return 32'hCAFE_0001;
      default: return {b, 8'h5A, ~b, 8'hC3};
    endcase
  endfunction

  // synchronous SRAM, 1-cycle read latency
  initial begin
    for (int i = 0; i < 256; i++) sram[i] = init_word(i);
    mem_q = 32'h0;
    forever begin
      @(posedge clk);
      if (bus.o_mem_en) begin
        if (bus.o_mem_we == 4'h0)
          mem_q <= sram[bus.o_mem_addr[9:2]];
        else
          for (int b = 0; b < 4; b++)
            if (bus.o_mem_we[b])
              sram[bus.o_mem_addr[9:2]][8*b +: 8] =
                bus.o_mem_wdata[8*b +: 8];
      end
    end
  end

  assign bus.i_mem_rdata = mem_q;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    bit rst, bit ir, logic [31:0] ia, bit fl, bit hd,
    bit lr, bit lw, logic [31:0] la,
    bit gi, bit gl, bit rvi, logic [31:0] rdi,
    bit rvl, logic [31:0] rdl, bit st);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.fl = fl;
    v.hd = hd; v.lr = lr; v.lw = lw; v.la = la;
    v.gi = gi; v.gl = gl; v.rvi = rvi; v.rdi = rdi;
    v.rvl = rvl; v.rdl = rdl; v.st = st;
    return v;
  endfunction

  task automatic apply(vec_t v);
    rst_n          = v.rst;
    bus.i_if_req   = v.ir;
    bus.i_if_addr  = v.ia;
    bus.i_if_flush = v.fl;
    bus.i_if_hold  = v.hd;
    bus.i_ls_req   = v.lr;
    bus.i_ls_we    = v.lw;
    bus.i_ls_wstrb = v.lw ? 4'hF : 4'h0;
    bus.i_ls_addr  = v.la;
    bus.i_ls_wdata = 32'h600D_F00D;
  endtask

  task automatic chk_row(int k, vec_t v);
    string p;
    p = $sformatf("row%0d", k);
    chk({p, " if_gnt"}, 32'(bus.o_if_gnt), 32'(v.gi));
    chk({p, " ls_gnt"}, 32'(bus.o_ls_gnt), 32'(v.gl));
    chk({p, " stall_f"}, 32'(bus.o_stall_f), 32'(v.st));
    chk({p, " if_rvalid"}, 32'(bus.o_if_rvalid), 32'(v.rvi));
    chk({p, " ls_rvalid"}, 32'(bus.o_ls_rvalid), 32'(v.rvl));
    chk({p, " ls_rdata"}, bus.o_ls_rdata, v.rdl);
    if (v.rst) chk({p, " if_rdata"}, bus.o_if_rdata, v.rdi);
  endtask

  // reference: expected outputs from the arbitration rules
  task automatic model_step();
    bit          rs, fresh, present, if_ok, egi, egl;
    bit          erv_i, erv_l, hd;
    logic [31:0] erd_i, erd_l, ga, ewd;
    logic [3:0]  ewe;
    rs      = rst_n;
    hd      = bus.i_if_hold;
    fresh   = rs && mdl_pend == 1 && !bus.i_if_flush;
    present = rs && mdl_full && !hd;
    if_ok   = rs && bus.i_if_req && !mdl_full &&
              !(fresh && hd);
    egi     = if_ok && (!bus.i_ls_req || mdl_starve >= STARVE);
    egl     = rs && bus.i_ls_req && !egi;
    erv_i   = present || (fresh && !hd);
    erd_i   = present ? mdl_skd : erv_i ? mdl_pdata : mdl_held;
    erv_l   = rs && mdl_pend >= 2;
    erd_l   = (rs && mdl_pend == 2) ? mdl_pdata : 32'h0;
    ga      = egl ? bus.i_ls_addr : egi ? bus.i_if_addr : 32'h0;
    ewe     = (egl && bus.i_ls_we) ? bus.i_ls_wstrb : 4'h0;
    ewd     = egl ? bus.i_ls_wdata : 32'h0;

    chk("mdl if_gnt", 32'(bus.o_if_gnt), 32'(egi));
    chk("mdl ls_gnt", 32'(bus.o_ls_gnt), 32'(egl));
    chk("mdl stall_f", 32'(bus.o_stall_f),
        32'(bus.i_if_req && !egi));
    chk("mdl if_rvalid", 32'(bus.o_if_rvalid), 32'(erv_i));
    chk("mdl ls_rvalid", 32'(bus.o_ls_rvalid), 32'(erv_l));
    chk("mdl ls_rdata", bus.o_ls_rdata, erd_l);
    chk("mdl mem_en", 32'(bus.o_mem_en), 32'(egi || egl));
    chk("mdl mem_we", 32'(bus.o_mem_we), 32'(ewe));
    chk("mdl mem_addr", bus.o_mem_addr, ga & 32'hFFFF_FFFC);
    chk("mdl mem_wdata", bus.o_mem_wdata, ewd);
    if (rs) chk("mdl if_rdata", bus.o_if_rdata, erd_i);

    if (!rs) begin
      mdl_starve = 0;
      mdl_pend   = 0;
      mdl_held   = 32'h0;
      mdl_full   = 1'b0;
    end else begin
      if (present) begin
        mdl_held = mdl_skd;
        mdl_full = 1'b0;
      end else if (fresh && !hd) begin
        mdl_held = mdl_pdata;
      end else if (fresh) begin
        mdl_full = 1'b1;
        mdl_skd  = mdl_pdata;
      end
      if (egi || !bus.i_if_req) mdl_starve = 0;
      else if (egl && mdl_starve < STARVE) mdl_starve++;
      mdl_pend = 0;
      if (egi) begin
        mdl_pend  = bus.i_if_flush ? 0 : 1;
        mdl_pdata = mdl_mem[ga[9:2]];
      end else if (egl) begin
        mdl_pend  = bus.i_ls_we ? 3 : 2;
        mdl_pdata = mdl_mem[ga[9:2]];
        for (int b = 0; b < 4; b++)
          if (ewe[b])
            mdl_mem[ga[9:2]][8*b +: 8] = ewd[8*b +: 8];
      end
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    mdl_starve = 0;
    mdl_pend   = 0;
    mdl_pdata  = 32'h0;
    mdl_held   = 32'h0;
    mdl_skd    = 32'h0;
    mdl_full   = 1'b0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = init_word(i);

    //           rst ir ia      fl hd lr lw la
    //           gi gl rvi rdi           rvl rdl          st
    tbl[0]  = mk(1,1,32'h0, 0,0,0,0,32'h0,
                 1,0,0,32'h0,        0,32'h0,        0);
    tbl[1]  = mk(1,1,32'h4, 0,0,0,0,32'h0,
                 1,0,1,32'h13,       0,32'h0,        0);
    tbl[2]  = mk(1,1,32'h8, 0,0,0,0,32'h0,
                 1,0,1,32'h93,       0,32'h0,        0);
    tbl[3]  = mk(1,0,32'h0, 0,0,0,0,32'h0,
                 0,0,1,32'h113,      0,32'h0,        0);
    tbl[4]  = mk(1,1,32'h10,0,0,1,0,32'h100,
                 0,1,0,32'h113,      0,32'h0,        1);
    tbl[5]  = mk(1,1,32'h10,0,0,0,0,32'h0,
                 1,0,0,32'h113,      1,32'hCAFE0001, 0);
    tbl[6]  = mk(1,0,32'h0, 0,0,0,0,32'h0,
                 0,0,1,32'h00400093, 0,32'h0,        0);
    tbl[7]  = mk(1,1,32'h30,0,0,1,1,32'h200,
                 0,1,0,32'h00400093, 0,32'h0,        1);
    tbl[8]  = mk(1,1,32'h30,0,0,1,1,32'h200,
                 0,1,0,32'h00400093, 1,32'h0,        1);
    tbl[9]  = mk(1,1,32'h30,0,0,1,1,32'h200,
                 0,1,0,32'h00400093, 1,32'h0,        1);
    tbl[10] = mk(1,1,32'h30,0,0,1,1,32'h200,
                 0,1,0,32'h00400093, 1,32'h0,        1);
    tbl[11] = mk(1,1,32'h30,0,0,1,1,32'h200,
                 1,0,0,32'h00400093, 1,32'h0,        0);
    tbl[12] = mk(1,0,32'h0, 0,1,1,1,32'h200,
                 0,1,0,32'h00400093, 0,32'h0,        0);
    tbl[13] = mk(1,1,32'h34,0,1,0,0,32'h0,
                 0,0,0,32'h00400093, 1,32'h0,        1);
    tbl[14] = mk(1,1,32'h34,0,1,0,0,32'h0,
                 0,0,0,32'h00400093, 0,32'h0,        1);
    tbl[15] = mk(1,1,32'h34,0,0,0,0,32'h0,
                 0,0,1,32'hDEADBEEF, 0,32'h0,        1);
    tbl[16] = mk(1,1,32'h34,0,0,0,0,32'h0,
                 1,0,0,32'hDEADBEEF, 0,32'h0,        0);
    tbl[17] = mk(1,1,32'h20,0,0,0,0,32'h0,
                 1,0,1,32'h22222222, 0,32'h0,        0);
    tbl[18] = mk(1,0,32'h0, 1,0,0,0,32'h0,
                 0,0,0,32'h22222222, 0,32'h0,        0);
    tbl[19] = mk(1,0,32'h0, 0,0,0,0,32'h0,
                 0,0,0,32'h22222222, 0,32'h0,        0);
    tbl[20] = mk(1,0,32'h0, 0,0,1,0,32'h100,
                 0,1,0,32'h22222222, 0,32'h0,        0);
    tbl[21] = mk(0,0,32'h0, 0,0,0,0,32'h0,
                 0,0,0,32'h0,        0,32'h0,        0);
    tbl[22] = mk(1,0,32'h0, 0,0,0,0,32'h0,
                 0,0,0,32'h0,        0,32'h0,        0);
    tbl[23] = mk(1,1,32'h0, 0,0,1,0,32'h101,
                 0,1,0,32'h0,        0,32'h0,        1);
    tbl[24] = mk(1,1,32'h0, 0,0,0,0,32'h0,
                 1,0,0,32'h0,        1,32'hCAFE0001, 0);
    tbl[25] = mk(1,0,32'h0, 0,0,0,0,32'h0,
                 0,0,1,32'h13,       0,32'h0,        0);

    apply(mk(0,0,32'h0,0,0,0,0,32'h0,
             0,0,0,32'h0,0,32'h0,0));
    repeat (2) begin
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
    end

    for (int k = 0; k < 26; k++) begin
      apply(tbl[k]);
      @(negedge clk);
      chk_row(k, tbl[k]);
      model_step();
      @(posedge clk);
      #1;
    end

    for (int c = 0; c < 3000; c++) begin
      rst_n          = $urandom_range(0, 99) != 0;
      bus.i_if_req   = $urandom_range(0, 2) != 0;
      bus.i_if_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      bus.i_if_flush = $urandom_range(0, 7) == 0;
      bus.i_if_hold  = $urandom_range(0, 3) == 0;
      bus.i_ls_req   = $urandom_range(0, 1) != 0;
      bus.i_ls_we    = $urandom_range(0, 1) != 0;
      bus.i_ls_wstrb = 4'($urandom_range(0, 15));
      bus.i_ls_addr  = 32'($urandom_range(0, 1023));
      bus.i_ls_wdata = $urandom;
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between the instruction fetch unit (IF port) and the load/store unit (LS port).
- Grants one access per cycle and routes each read response back to its owner.
- Holds the last IF instruction so a decode stall does not lose it.
- Drives the fetch-stall request to the hazard logic when IF loses arbitration.

Parameters:
- ADDR_W, 32, byte-address width of both ports and the memory.
- DATA_W, 32, data/instruction width; must be 32.
- STARVE_MAX, 4, number of consecutive LS grants taken while IF is waiting before IF is forced to win; legal range 1..15.

Ports:
- clk_sys  in  1  system clock, rising edge
- rst_sys  in  1  synchronous reset, active-low
- i_if_req  in  1  IF read request
- i_if_addr  in  ADDR_W  IF byte address (PC)
- i_if_flush  in  1  discard any IF response due next cycle
- i_if_hold  in  1  decode stalled; hold o_if_rdata
- o_if_gnt  out  1  IF request accepted this cycle
- o_if_rvalid  out  1  o_if_rdata is fresh this cycle
- o_if_rdata  out  DATA_W  instruction, held between responses
- o_stall_f  out  1  equals i_if_req & ~o_if_gnt
- i_ls_req  in  1  LS request
- i_ls_we  in  1  1 = write, 0 = read
- i_ls_wstrb  in  4  byte write strobes
- i_ls_addr  in  ADDR_W  LS byte address
- i_ls_wdata  in  DATA_W  LS write data
- o_ls_gnt  out  1  LS request accepted this cycle
- o_ls_rvalid  out  1  LS response (read data or write ack) this cycle
- o_ls_rdata  out  DATA_W  LS read data; 0 on write ack
- o_mem_en  out  1  SRAM enable
- o_mem_we  out  4  SRAM byte write enables
- o_mem_addr  out  ADDR_W  SRAM byte address, bits [1:0] forced to 0
- o_mem_wdata  out  DATA_W  SRAM write data
- i_mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after a read enable

Behaviour:
- Grant is combinational in the request cycle. The memory-side signals are combinational copies of the winner's request.
- o_mem_en = o_if_gnt | o_ls_gnt. o_mem_we = i_ls_wstrb only when LS is granted with i_ls_we=1, else 0.
- At most one grant per cycle.
- Arbitration:
  - LS wins by default.
  - IF wins when LS is idle, or when starve_cnt == STARVE_MAX.
- Starvation counter starve_cnt, 4 bits:
  - increments when LS is granted while i_if_req=1;
  - clears when IF is granted, or when i_if_req=0;
  - saturates at STARVE_MAX.
- Response owner register rsp_own, states NONE / IF / LS_RD / LS_WR:
  - loaded each cycle from the current grant (NONE if no grant);
  - the IF state is written as NONE if i_if_flush is high in the grant cycle.
  - i_if_flush also clears rsp_own=IF in the following cycle. In that case o_if_rvalid=0 and o_if_rdata is unchanged.
- Response routing:
  - rsp_own=IF: o_if_rvalid=1, and o_if_rdata loads i_mem_rdata.
  - rsp_own=LS_RD: o_ls_rvalid=1, o_ls_rdata=i_mem_rdata.
  - rsp_own=LS_WR: o_ls_rvalid=1, o_ls_rdata=0.
- IF data hold register:
  - updates only on a valid IF response while i_if_hold=0;
  - if i_if_hold=1 when a response arrives, the data goes to a 1-entry skid register and is presented once hold drops. o_if_rvalid is pulsed in that cycle.
  - o_if_gnt is forced 0 while the skid register is full, so it never overflows.
- Latency: IF and LS reads take 1 cycle from grant to rvalid. Write ack also takes 1 cycle.
- Same-cycle IF and LS requests with STARVE_MAX reached: IF granted, LS stalls (o_ls_gnt=0). The LS requester must hold its request.
- Reset (rst_sys=0 at a clock edge):
  - rsp_own=NONE, starve_cnt=0, skid empty, o_if_rdata=0;
  - all rvalid and gnt outputs are 0 after the edge.
  - A response in flight at reset is dropped.
- Misaligned LS address: bits [1:0] are ignored. No error is raised.

Decomposition:
- Shared core package holds:
  - the rsp_own encoding (NONE=0, IF=1, LS_RD=2, LS_WR=3);
  - the DATA_W=32 constant;
  - the STARVE_MAX default.
- One sub-module, imem_if_skid: the 1-entry hold/skid buffer for the IF return path.
- Flops use the existing DFF_RST_EN_CLR primitive.

Test Plan:
- IF only, addr 0x0,0x4,0x8 on consecutive cycles, mem returns 0x13,0x93,0x113 -> o_if_gnt=1 every cycle, o_if_rvalid each following cycle with matching data, o_stall_f=0.
- LS read of 0x100 and IF of 0x10 in the same cycle -> o_ls_gnt=1, o_stall_f=1; next cycle o_ls_rvalid=1 with o_ls_rdata=mem[0x100], and IF is granted.
- LS held continuously (writes, wstrb=0xF) with IF requesting, STARVE_MAX=4 -> 4 LS grants, IF granted on the 5th cycle, then LS resumes; starve_cnt returns to 0.
- IF granted at 0x20 with i_if_flush=1 the next cycle -> o_if_rvalid=0, o_if_rdata keeps its prior value.
- IF response 0xDEADBEEF arrives with i_if_hold=1 for 3 cycles -> o_if_gnt=0 during the hold, o_if_rdata=0xDEADBEEF with rvalid in the cycle hold drops.
- rst_sys=0 the cycle after an LS read grant -> no o_ls_rvalid, all outputs 0, normal arbitration on release.
